// File: rtl/kogge_stone_pipe.sv
// rtl/kogge_stone_pipe.sv - pipelined Kogge-Stone add/subtract with valid/ready flow control
// Pre-process stage, one registered stage per prefix level, then a registered sum stage.
module kogge_stone_pipe #(
    parameter  int WIDTH  = 16,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Index 0 is the pre-process stage; index k+1 is the output of prefix level k.
    logic [LEVELS:0][WIDTH-1:0]   g_q;
    logic [LEVELS:0][WIDTH-1:0]   g_d;
    logic [LEVELS-1:0][WIDTH-1:0] p_q;
    logic [LEVELS-1:0][WIDTH-1:0] p_d;
    logic [LEVELS:0][WIDTH-1:0]   po_q;
    logic [LEVELS:0]              v_q;
    logic [LEVELS:0]              c0_q;
    logic [LEVELS:0]              am_q;
    logic [LEVELS:0]              bm_q;

    logic [WIDTH-1:0] b_eff;
    logic             c_in;
    logic [WIDTH-1:0] pre_p;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    assign in_ready = !out_valid || out_ready;

    always_comb begin
        b_eff  = sub ? ~b : b;
        c_in   = sub | cin;
        pre_p  = a ^ b_eff;
        g_d    = '0;
        p_d    = '0;
        g_d[0] = a & b_eff;
        // Carry-in folded into bit 0 so the prefix tree needs no separate carry input.
        g_d[0][0] = g_d[0][0] | (pre_p[0] & c_in);
        p_d[0] = pre_p;
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                int span;
                int j;
                span = 1 << k;
                j    = (i >= span) ? i - span : i;
                if (i >= span) begin
                    g_d[k+1][i] = g_q[k][i] | (p_q[k][i] & g_q[k][j]);
                end else begin
                    g_d[k+1][i] = g_q[k][i];
                end
            end
        end
        // Propagate only matters for black cells; groups already reaching bit 0 keep 0.
        for (int k = 0; k < LEVELS - 1; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                int span;
                int j;
                span = 1 << k;
                j    = (i >= span) ? i - span : i;
                if (i >= 2 * span) begin
                    p_d[k+1][i] = p_q[k][i] & p_q[k][j];
                end else begin
                    p_d[k+1][i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        carry  = {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
        sum_d  = po_q[LEVELS] ^ carry;
        cout_d = g_q[LEVELS][WIDTH-1];
        ovf_d  = (am_q[LEVELS] == bm_q[LEVELS]) && (sum_d[WIDTH-1] != am_q[LEVELS]);
    end

    // A single enable for every stage: a stall freezes the whole pipe, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q       <= '0;
            p_q       <= '0;
            po_q      <= '0;
            v_q       <= '0;
            c0_q      <= '0;
            am_q      <= '0;
            bm_q      <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (in_ready) begin
            g_q       <= g_d;
            p_q       <= p_d;
            po_q      <= {po_q[LEVELS-1:0], pre_p};
            v_q       <= {v_q[LEVELS-1:0], in_valid};
            c0_q      <= {c0_q[LEVELS-1:0], c_in};
            am_q      <= {am_q[LEVELS-1:0], a[WIDTH-1]};
            bm_q      <= {bm_q[LEVELS-1:0], b_eff[WIDTH-1]};
            out_valid <= v_q[LEVELS];
            sum       <= sum_d;
            cout      <= cout_d;
            ovf       <= ovf_d;
        end
    end

endmodule
